fuzz_sig_collector: RTL

Downstream consumer of the fuzz DUT output `y`: samples the 199-bit result bus on each clock while enabled, XOR-folds it to 32 bits and compacts it into a 32-bit MISR signature. It replaces the per-cycle `$strobe` dump with a single signature per run, so synthesised and reference netlists can be compared with one word. It sits between `top` and the run controller and is clocked from the same `clk`.

---
 rtl/fuzz_sig_pkg.sv | 17 +
 rtl/fuzz_sig_fold.sv | 26 ++
 rtl/fuzz_sig_collector.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fuzz_sig_pkg.sv
// Shared types and default constants for the fuzz result signature collector.
// Used by fuzz_sig_collector and fuzz_sig_fold.
package fuzz_sig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [31:0] DEF_POLY    = 32'h04C11DB7;
    localparam logic [31:0] DEF_SEED    = 32'hFFFFFFFF;
    // ceil(199 / 32): number of 32-bit words in the zero-extended result bus
    localparam int          FOLD_WORDS  = 7;

endpackage

// File: rtl/fuzz_sig_fold.sv
// Combinational XOR fold of the zero-extended result bus into one SIG_W-bit word.
module fuzz_sig_fold
    import fuzz_sig_pkg::*;
#(
    parameter int Y_W     = 199,
    parameter int SIG_W   = 32,
    parameter int N_WORDS = FOLD_WORDS
) (
    input  logic [Y_W-1:0]   y_i,
    output logic [SIG_W-1:0] fold_o
);

    localparam int EXT_W = N_WORDS * SIG_W;

    logic [EXT_W-1:0] y_ext;

    always_comb begin
        y_ext          = '0;
        y_ext[Y_W-1:0] = y_i;
        fold_o         = '0;
        for (int w = 0; w < N_WORDS; w++) begin
            fold_o = fold_o ^ y_ext[w*SIG_W +: SIG_W];
        end
    end

endmodule

// File: rtl/fuzz_sig_collector.sv
// Samples the fuzz DUT result bus, XOR-folds it and compacts it into a MISR signature.
// Optional expected-signature comparator enabled by defining FUZZ_SIG_CMP_EN.
module fuzz_sig_collector
    import fuzz_sig_pkg::*;
#(
    parameter int               Y_W     = 199,
    parameter int               SIG_W   = 32,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED    = SIG_W'(DEF_SEED),
    parameter int               NUM_VEC = 21
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             en_i,
    input  logic [Y_W-1:0]   y_i,
    output logic             busy_o,
    output logic             sig_valid_o,
    output logic [SIG_W-1:0] sig_o,
    output logic [15:0]      vec_count_o
`ifdef FUZZ_SIG_CMP_EN
    ,
    input  logic [SIG_W-1:0] exp_sig_i,
    output logic             mismatch_o
`endif
);

    localparam int          N_WORDS   = (Y_W + SIG_W - 1) / SIG_W;
    localparam logic [15:0] NUM_VEC_C = 16'(NUM_VEC);

    state_e           state_q;
    logic [Y_W-1:0]   y_q;
    logic             y_vld_q;
    logic [SIG_W-1:0] fold_q;
    logic             fold_vld_q;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [15:0]      cnt_q;
    logic             busy_q;
    logic             sig_valid_q;
    logic [SIG_W-1:0] fold_w;
    logic             accept;

    fuzz_sig_fold #(
        .Y_W     (Y_W),
        .SIG_W   (SIG_W),
        .N_WORDS (N_WORDS)
    ) u_fold (
        .y_i    (y_q),
        .fold_o (fold_w)
    );

    always_comb begin
        accept = (state_q == ST_RUN) && en_i && (cnt_q < NUM_VEC_C);
        sig_d  = sig_q;
        if (fold_vld_q) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold_q;
        end
    end

    // Pipeline: sample register -> fold register -> MISR, so a sample lands in sig two edges later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            y_q         <= '0;
            y_vld_q     <= 1'b0;
            fold_q      <= '0;
            fold_vld_q  <= 1'b0;
            sig_q       <= SEED;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            sig_valid_q <= 1'b0;
        end else begin
            y_vld_q    <= accept;
            fold_vld_q <= y_vld_q;
            sig_q      <= sig_d;
            if (accept) begin
                y_q   <= y_i;
                cnt_q <= cnt_q + 16'd1;
            end
            if (y_vld_q) begin
                fold_q <= fold_w;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q     <= ST_RUN;
                        sig_q       <= SEED;
                        cnt_q       <= '0;
                        y_vld_q     <= 1'b0;
                        fold_q      <= '0;
                        fold_vld_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        sig_valid_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == NUM_VEC_C) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_q     <= ST_DONE;
                    busy_q      <= 1'b0;
                    sig_valid_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef FUZZ_SIG_CMP_EN
    logic mismatch_q;

    // Compare against the value sig takes on DONE entry, which is sig_d during DRAIN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mismatch_q <= 1'b0;
        end else if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_i) begin
            mismatch_q <= 1'b0;
        end else if (state_q == ST_DRAIN) begin
            mismatch_q <= (sig_d != exp_sig_i);
        end
    end

    assign mismatch_o = mismatch_q;
`endif

    assign busy_o      = busy_q;
    assign sig_valid_o = sig_valid_q;
    assign sig_o       = sig_q;
    assign vec_count_o = cnt_q;

endmodule
